// File: rtl/frv_ext_irq_ctrl_if.sv
// Register port bundle for frv_ext_irq_ctrl.
// The master holds cfg_valid until the one-cycle cfg_ready pulse.
interface frv_ext_irq_ctrl_if;
  logic        cfg_valid;
  logic        cfg_write;
  logic [3:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        cfg_ready;
  logic [31:0] cfg_rdata;

  modport master (
    output cfg_valid,
    output cfg_write,
    output cfg_addr,
    output cfg_wdata,
    input  cfg_ready,
    input  cfg_rdata
  );

  modport slave (
    input  cfg_valid,
    input  cfg_write,
    input  cfg_addr,
    input  cfg_wdata,
    output cfg_ready,
    output cfg_rdata
  );
endinterface

// File: rtl/frv_ext_irq_ctrl.sv
// External interrupt controller with claim/complete register port.
// Define FRV_EXTINT_SYNC_EN to add 2-flop synchronisers on irq_in.
module frv_ext_irq_ctrl #(
  parameter int NUM_SRC = 15
) (
  input  logic               g_clk,
  input  logic               g_resetn,
  input  logic [NUM_SRC-1:0] irq_in,
  frv_ext_irq_ctrl_if.slave  cfg,
  output logic               ex_pending,
  output logic [3:0]         ex_cause
);

  localparam logic [3:0] A_EN    = 4'h0;
  localparam logic [3:0] A_MODE  = 4'h4;
  localparam logic [3:0] A_PEND  = 4'h8;
  localparam logic [3:0] A_CLAIM = 4'hC;

  typedef enum logic {
    IDLE,
    SERVICE
  } state_t;

  state_t             state_q;
  logic [NUM_SRC-1:0] en_q;
  logic [NUM_SRC-1:0] mode_q;
  logic [NUM_SRC-1:0] pend_q;
  logic [NUM_SRC-1:0] pend_d;
  logic [NUM_SRC-1:0] prev_q;
  logic [NUM_SRC-1:0] insvc_q;
  logic [NUM_SRC-1:0] line;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] cand;
  logic [NUM_SRC-1:0] cand_oh;
  logic [NUM_SRC-1:0] clr;
  logic [3:0]         cand_id;
  logic [3:0]         svc_id;
  logic               ready_q;
  logic [31:0]        rdata_q;
  logic [31:0]        rdata_d;
  logic               acc;
  logic               acc_wr;
  logic               acc_rd;
  logic               claim_take;
  logic               claim_done;

`ifdef FRV_EXTINT_SYNC_EN
  logic [NUM_SRC-1:0] sync1_q;
  logic [NUM_SRC-1:0] sync2_q;

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign line = sync2_q;
`else
  assign line = irq_in;
`endif

  assign acc    = cfg.cfg_valid & ~ready_q;
  assign acc_wr = acc & cfg.cfg_write;
  assign acc_rd = acc & ~cfg.cfg_write;

  // Lowest index wins: scan downwards so the last hit is kept.
  always_comb begin
    cand    = pend_q & en_q & ~insvc_q;
    cand_oh = '0;
    cand_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) begin
        cand_oh    = '0;
        cand_oh[i] = 1'b1;
        cand_id    = 4'(i + 1);
      end
    end
  end

  always_comb begin
    svc_id = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (insvc_q[i]) begin
        svc_id = 4'(i + 1);
      end
    end
  end

  assign claim_take = acc_rd
                    & (cfg.cfg_addr == A_CLAIM)
                    & (state_q == IDLE)
                    & (|cand);

  assign claim_done = acc_wr
                    & (cfg.cfg_addr == A_CLAIM)
                    & (state_q == SERVICE)
                    & (cfg.cfg_wdata == {28'd0, svc_id});

  // Edge bits: a new rise beats any clear in the same cycle.
  always_comb begin
    rise = line & ~prev_q;
    clr  = '0;
    if (acc_wr && cfg.cfg_addr == A_PEND) begin
      clr = cfg.cfg_wdata[NUM_SRC-1:0];
    end
    if (claim_take) begin
      clr = clr | cand_oh;
    end
    pend_d = (mode_q & (rise | (pend_q & ~clr)))
           | (~mode_q & line);
  end

  always_comb begin
    rdata_d = '0;
    unique case (cfg.cfg_addr)
      A_EN:    rdata_d = 32'(en_q);
      A_MODE:  rdata_d = 32'(mode_q);
      A_PEND:  rdata_d = 32'(pend_q);
      A_CLAIM: rdata_d = claim_take ? 32'(cand_id) : 32'd0;
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q    <= IDLE;
      en_q       <= '0;
      mode_q     <= '0;
      pend_q     <= '0;
      prev_q     <= '0;
      insvc_q    <= '0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      ex_pending <= 1'b0;
      ex_cause   <= '0;
    end else begin
      ready_q    <= acc;
      rdata_q    <= acc_rd ? rdata_d : 32'd0;
      prev_q     <= line;
      pend_q     <= pend_d;
      ex_pending <= |cand;
      ex_cause   <= cand_id;
      if (acc_wr && cfg.cfg_addr == A_EN) begin
        en_q <= cfg.cfg_wdata[NUM_SRC-1:0];
      end
      if (acc_wr && cfg.cfg_addr == A_MODE) begin
        mode_q <= cfg.cfg_wdata[NUM_SRC-1:0];
      end
      unique case (state_q)
        IDLE: begin
          if (claim_take) begin
            insvc_q <= cand_oh;
            state_q <= SERVICE;
          end
        end
        SERVICE: begin
          if (claim_done) begin
            insvc_q <= '0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign cfg.cfg_ready = ready_q;
  assign cfg.cfg_rdata = rdata_q;

endmodule

// File: tb/tb_frv_ext_irq_ctrl.sv
// Randomised bench for frv_ext_irq_ctrl against a queue-based model.
// Directed scenarios first, then a random irq/register-traffic soak.
module tb_frv_ext_irq_ctrl;

  localparam int N = 15;
`ifdef FRV_EXTINT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam logic [N-1:0] MASK = '1;

  logic         g_clk;
  logic         g_resetn;
  logic [N-1:0] irq;
  logic         ex_pending;
  logic [3:0]   ex_cause;

  frv_ext_irq_ctrl_if bus ();

  frv_ext_irq_ctrl #(.NUM_SRC(N)) dut (
    .g_clk      (g_clk),
    .g_resetn   (g_resetn),
    .irq_in     (irq),
    .cfg        (bus),
    .ex_pending (ex_pending),
    .ex_cause   (ex_cause)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference state
  logic [N-1:0] m_en, m_mode, m_pend, m_prev;
  logic [N-1:0] hist[$];
  int           m_svc;
  logic         m_ready;
  logic [31:0]  m_rdata;
  logic         m_exp;
  int           m_cause;

  task automatic model_edge();
    logic [N-1:0] line, pn, clr, en_n, mode_n;
    logic [31:0]  rd;
    int           cause, svc_n;
    bit           acc;
    hist.push_front(g_resetn ? irq : '0);
    while (hist.size() > LAT + 1) void'(hist.pop_back());
    if (!g_resetn) begin
      m_en = '0; m_mode = '0; m_pend = '0; m_prev = '0;
      m_svc = 0; m_ready = 0; m_rdata = '0;
      m_exp = 0; m_cause = 0;
      return;
    end
    line = hist[LAT];
    cause = 0;
    for (int i = 0; i < N; i++)
      if (cause == 0 && m_pend[i] && m_en[i] && (i + 1) != m_svc)
        cause = i + 1;
    acc = bus.cfg_valid && !m_ready;
    rd = '0; clr = '0;
    en_n = m_en; mode_n = m_mode; svc_n = m_svc;
    if (acc) begin
      case (bus.cfg_addr)
        4'h0: if (bus.cfg_write) en_n = bus.cfg_wdata[N-1:0];
              else rd = 32'(m_en);
        4'h4: if (bus.cfg_write) mode_n = bus.cfg_wdata[N-1:0];
              else rd = 32'(m_mode);
        4'h8: if (bus.cfg_write) clr = bus.cfg_wdata[N-1:0];
              else rd = 32'(m_pend);
        4'hC: if (bus.cfg_write) begin
                if (m_svc != 0 && bus.cfg_wdata == 32'(m_svc))
                  svc_n = 0;
              end else if (m_svc == 0 && cause != 0) begin
                rd = 32'(cause);
                svc_n = cause;
                clr[cause-1] = 1'b1;
              end
        default: ;
      endcase
    end
    pn = m_pend;
    for (int i = 0; i < N; i++) begin
      if (!m_mode[i]) pn[i] = line[i];
      else if (line[i] && !m_prev[i]) pn[i] = 1'b1;
      else if (clr[i]) pn[i] = 1'b0;
    end
    m_pend = pn; m_prev = line;
    m_en = en_n; m_mode = mode_n; m_svc = svc_n;
    m_exp = (cause != 0);
    m_cause = cause;
    m_ready = acc;
    m_rdata = (acc && !bus.cfg_write) ? rd : '0;
  endtask

  task automatic tick();
    @(posedge g_clk);
    model_edge();
    @(negedge g_clk);
    chk("ready", 32'(bus.cfg_ready), 32'(m_ready));
    chk("rdata", bus.cfg_rdata, m_rdata);
    chk("ex_pending", 32'(ex_pending), 32'(m_exp));
    chk("ex_cause", 32'(ex_cause), 32'(m_cause));
  endtask

  task automatic cfg_acc(input bit wr, input logic [3:0] a,
                         input logic [31:0] d,
                         output logic [31:0] rd);
    int n;
    n = 0;
    bus.cfg_valid = 1'b1;
    bus.cfg_write = wr;
    bus.cfg_addr  = a;
    bus.cfg_wdata = d;
    do begin
      tick();
      n++;
    end while (!bus.cfg_ready && n < 8);
    chk("acc_ready", 32'(bus.cfg_ready), 32'd1);
    rd = bus.cfg_rdata;
    bus.cfg_valid = 1'b0;
    tick();
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] rd;
    cfg_acc(1'b1, a, d, rd);
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a,
                        input logic [31:0] exp);
    logic [31:0] rd;
    cfg_acc(1'b0, a, 32'd0, rd);
    chk(tag, rd, exp);
  endtask

  initial begin
    int n;
    g_resetn = 1'b0;
    irq = '0;
    bus.cfg_valid = 1'b0;
    bus.cfg_write = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_wdata = '0;
    for (int i = 0; i <= LAT; i++) hist.push_back('0);
    @(negedge g_clk);
    tick();
    tick();
    chk("rst_pend", 32'(ex_pending), 32'd0);
    chk("rst_cause", 32'(ex_cause), 32'd0);
    chk("rst_ready", 32'(bus.cfg_ready), 32'd0);
    g_resetn = 1'b1;
    tick();
    rd_chk("rst_en", 4'h0, 32'd0);
    rd_chk("rst_mode", 4'h4, 32'd0);
    rd_chk("unmapped", 4'h2, 32'd0);

    // Level source latency, assert and deassert
    wr(4'h0, 32'h1);
    wr(4'h4, 32'h0);
    irq[0] = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!ex_pending && n < 10);
    chk("lvl_lat", 32'(n), 32'(LAT + 2));
    chk("lvl_cause", 32'(ex_cause), 32'd1);
    irq[0] = 1'b0;
    n = 0;
    do begin tick(); n++; end while (ex_pending && n < 10);
    chk("lvl_drop", 32'(n), 32'(LAT + 2));

    // Priority and claim
    wr(4'h4, 32'h24);
    wr(4'h0, 32'h24);
    irq[2] = 1'b1;
    irq[5] = 1'b1;
    repeat (LAT + 3) tick();
    chk("prio_cause", 32'(ex_cause), 32'd3);
    rd_chk("claim3", 4'hC, 32'd3);
    chk("next_cause", 32'(ex_cause), 32'd6);
    chk("next_pend", 32'(ex_pending), 32'd1);
    rd_chk("claim_busy", 4'hC, 32'd0);
    wr(4'hC, 32'd3);
    rd_chk("claim6", 4'hC, 32'd6);
    wr(4'hC, 32'd6);
    irq = '0;
    repeat (LAT + 3) tick();

    // Edge collision with PENDING W1C
    wr(4'h4, 32'h2);
    wr(4'h0, 32'h2);
    irq[1] = 1'b1;
    repeat (LAT) tick();
    wr(4'h8, 32'h2);
    rd_chk("collide", 4'h8, 32'h2);
    rd_chk("claim2", 4'hC, 32'd2);
    wr(4'hC, 32'd2);
    irq = '0;

    // Bad completion
    wr(4'h4, 32'h8);
    wr(4'h0, 32'h8);
    irq[3] = 1'b1;
    repeat (LAT + 2) tick();
    rd_chk("claim4", 4'hC, 32'd4);
    wr(4'hC, 32'd7);
    chk("bad_masked", 32'(ex_pending), 32'd0);
    rd_chk("bad_busy", 4'hC, 32'd0);
    wr(4'hC, 32'd4);
    irq = '0;

    // Disabled and empty
    wr(4'h0, 32'h0);
    wr(4'h4, 32'h0);
    irq = MASK;
    repeat (LAT + 3) tick();
    chk("dis_pend", 32'(ex_pending), 32'd0);
    chk("dis_cause", 32'(ex_cause), 32'd0);
    rd_chk("dis_pvec", 4'h8, 32'(MASK));
    rd_chk("dis_claim", 4'hC, 32'd0);

    // Reset in the middle of an access while in service
    wr(4'h0, 32'(MASK));
    tick();
    rd_chk("mid_claim", 4'hC, 32'd1);
    bus.cfg_valid = 1'b1;
    bus.cfg_write = 1'b0;
    bus.cfg_addr  = 4'h0;
    g_resetn = 1'b0;
    tick();
    chk("mid_ready", 32'(bus.cfg_ready), 32'd0);
    chk("mid_rdata", bus.cfg_rdata, 32'd0);
    chk("mid_pend", 32'(ex_pending), 32'd0);
    chk("mid_cause", 32'(ex_cause), 32'd0);
    bus.cfg_valid = 1'b0;
    irq = '0;
    g_resetn = 1'b1;
    tick();
    rd_chk("mid_en", 4'h0, 32'd0);

    // Random soak
    for (int it = 0; it < 3000; it++) begin
      logic [31:0] d, r;
      logic [3:0]  a;
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 7) == 0) irq[b] = ~irq[b];
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 5))
          0: a = 4'h0;
          1: a = 4'h4;
          2: a = 4'h8;
          3, 4: a = 4'hC;
          default: a = 4'($urandom);
        endcase
        d = $urandom;
        if (a == 4'hC)
          d = ($urandom_range(0, 1) == 0) ? 32'(m_svc)
                                          : 32'($urandom_range(0, 15));
        cfg_acc($urandom_range(0, 1) == 1, a, d, r);
      end else begin
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
